// File: rtl/lru8_victim_sel.sv
// True-LRU age tracker for 8-way sets, with a victim request/hold/ack handshake.
// Define LRU8_DOUBLE_HIT_EN to add a second hit port (hit2_en/hit2_set/hit2_way).
module lru8_victim_sel #(
  parameter  int SETS = 16,
  localparam int SETW = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hit_en,
  input  logic [SETW-1:0] hit_set,
  input  logic [2:0]      hit_way,
`ifdef LRU8_DOUBLE_HIT_EN
  input  logic            hit2_en,
  input  logic [SETW-1:0] hit2_set,
  input  logic [2:0]      hit2_way,
`endif
  input  logic            vic_req,
  input  logic [SETW-1:0] vic_set,
  output logic            vic_rdy,
  output logic            vic_vld,
  output logic [2:0]      vic_way,
  input  logic            vic_ack,
  output logic            vic_err,
  output logic            hit_drop
);

  typedef enum logic [1:0] {INIT, IDLE, LOOKUP, HOLD} state_t;

  localparam logic [SETW-1:0] LAST_SET = SETW'(SETS - 1);

  state_t          state_reg, state_next;
  logic [SETW-1:0] init_ptr_reg;
  logic [SETW-1:0] lat_set_reg;
  logic [23:0]     age_reg  [SETS];
  logic [23:0]     age_next [SETS];

  // Way k's age lives in bits [3k+2:3k].
  function automatic logic [23:0] promote(input logic [23:0] ages, input logic [2:0] w);
    logic [23:0] res;
    logic [2:0]  old_age;
    logic [2:0]  a;
    old_age = ages[3*w +: 3];
    res     = ages;
    for (int k = 0; k < 8; k++) begin
      a = ages[3*k +: 3];
      if (3'(k) == w)
        res[3*k +: 3] = 3'd0;
      else if (a < old_age)
        res[3*k +: 3] = a + 3'd1;
    end
    return res;
  endfunction

  function automatic logic [23:0] ident_ages();
    logic [23:0] res;
    for (int k = 0; k < 8; k++)
      res[3*k +: 3] = 3'(k);
    return res;
  endfunction

  logic active, ack_fire;
  logic hit1_col, hit1_ok;
  logic hit2_col, hit2_ok;
  logic [SETW-1:0] hit2_s;
  logic [2:0]      hit2_w;

  assign active   = !rst && (state_reg != INIT);
  assign ack_fire = !rst && (state_reg == HOLD) && vic_ack;
  assign hit1_col = hit_en && active && ack_fire && (hit_set == lat_set_reg);
  assign hit1_ok  = hit_en && active && !hit1_col;

`ifdef LRU8_DOUBLE_HIT_EN
  assign hit2_s   = hit2_set;
  assign hit2_w   = hit2_way;
  assign hit2_col = hit2_en && active && ack_fire && (hit2_set == lat_set_reg);
  assign hit2_ok  = hit2_en && active && !hit2_col;
`else
  assign hit2_s   = '0;
  assign hit2_w   = '0;
  assign hit2_col = 1'b0;
  assign hit2_ok  = 1'b0;
`endif

  // hit2 is applied first so that hit_way ends at age 0 and hit2_way at age 1.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_set
    logic [23:0] upd;
    always_comb begin
      upd = age_reg[gi];
      if (hit2_ok && (hit2_s == SETW'(gi)))
        upd = promote(upd, hit2_w);
      if (hit1_ok && (hit_set == SETW'(gi)))
        upd = promote(upd, hit_way);
      if (ack_fire && (lat_set_reg == SETW'(gi)))
        upd = promote(upd, vic_way);
      if (!rst && (state_reg == INIT) && (init_ptr_reg == SETW'(gi)))
        upd = ident_ages();
    end
    assign age_next[gi] = upd;
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < SETS; s++)
      age_reg[s] <= age_next[s];
  end

  // Selection reads the post-hit ages so a same-cycle hit to the latched set is seen.
  logic [23:0] sel_ages;
  logic [2:0]  sel_way;
  logic        sel_found;

  always_comb begin
    sel_ages  = age_next[lat_set_reg];
    sel_way   = 3'd0;
    sel_found = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (sel_ages[3*k +: 3] == 3'd7) begin
        sel_way   = 3'(k);
        sel_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= INIT;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INIT:    if (init_ptr_reg == LAST_SET) state_next = IDLE;
      IDLE:    if (vic_req) state_next = LOOKUP;
      LOOKUP:  state_next = HOLD;
      HOLD:    if (vic_ack) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    vic_rdy = 1'b0;
    if (state_reg == IDLE)
      vic_rdy = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_ptr_reg <= '0;
      lat_set_reg  <= '0;
      vic_vld      <= 1'b0;
      vic_way      <= 3'd0;
      vic_err      <= 1'b0;
      hit_drop     <= 1'b0;
    end else begin
      vic_err  <= 1'b0;
      hit_drop <= hit1_col || hit2_col;
      if (state_reg == INIT)
        init_ptr_reg <= init_ptr_reg + 1'b1;
      if ((state_reg == IDLE) && vic_req)
        lat_set_reg <= vic_set;
      if (state_reg == LOOKUP) begin
        vic_way <= sel_way;
        vic_vld <= 1'b1;
        vic_err <= !sel_found;
      end
      if (ack_fire)
        vic_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lru8_victim_sel.sv
// Directed bench for lru8_victim_sel: hit-update vector table plus handshake sequences.
module tb_lru8_victim_sel;

  logic       clk = 1'b0;
  logic       rst;
  logic       hit_en;
  logic [3:0] hit_set;
  logic [2:0] hit_way;
`ifdef LRU8_DOUBLE_HIT_EN
  logic       hit2_en  = 1'b0;
  logic [3:0] hit2_set = '0;
  logic [2:0] hit2_way = '0;
`endif
  logic       vic_req;
  logic [3:0] vic_set;
  logic       vic_rdy;
  logic       vic_vld;
  logic [2:0] vic_way;
  logic       vic_ack;
  logic       vic_err;
  logic       hit_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lru8_victim_sel #(.SETS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .hit_en   (hit_en),
    .hit_set  (hit_set),
    .hit_way  (hit_way),
`ifdef LRU8_DOUBLE_HIT_EN
    .hit2_en  (hit2_en),
    .hit2_set (hit2_set),
    .hit2_way (hit2_way),
`endif
    .vic_req  (vic_req),
    .vic_set  (vic_set),
    .vic_rdy  (vic_rdy),
    .vic_vld  (vic_vld),
    .vic_way  (vic_way),
    .vic_ack  (vic_ack),
    .vic_err  (vic_err),
    .hit_drop (hit_drop)
  );

  typedef struct {
    int          set;
    int          way;
    logic [23:0] exp;
  } hit_vec_t;

  hit_vec_t vecs [7];

  // Arguments are the ages of ways 0..7.
  function automatic logic [23:0] mk(int a0, int a1, int a2, int a3,
                                     int a4, int a5, int a6, int a7);
    return {3'(a7), 3'(a6), 3'(a5), 3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic chk_set(input string name, input int s, input logic [23:0] exp);
    chk(name, 32'(dut.age_reg[s]), 32'(exp));
  endtask

  task automatic do_req(input int s);
    vic_req = 1'b1;
    vic_set = 4'(s);
    step();
    vic_req = 1'b0;
  endtask

  task automatic hit(input int s, input int w);
    hit_en  = 1'b1;
    hit_set = 4'(s);
    hit_way = 3'(w);
    step();
    hit_en  = 1'b0;
  endtask

  initial begin
    logic [23:0] id;
    id = mk(0, 1, 2, 3, 4, 5, 6, 7);

    vecs[0] = '{1, 3, mk(1, 2, 3, 0, 4, 5, 6, 7)};
    vecs[1] = '{1, 7, mk(2, 3, 4, 1, 5, 6, 7, 0)};
    vecs[2] = '{1, 7, mk(2, 3, 4, 1, 5, 6, 7, 0)};
    vecs[3] = '{1, 0, mk(0, 3, 4, 2, 5, 6, 7, 1)};
    vecs[4] = '{1, 6, mk(1, 4, 5, 3, 6, 7, 0, 2)};
    vecs[5] = '{1, 2, mk(2, 5, 0, 4, 6, 7, 1, 3)};
    vecs[6] = '{9, 4, mk(1, 2, 3, 4, 0, 5, 6, 7)};

    rst = 1'b1; hit_en = 1'b0; hit_set = '0; hit_way = '0;
    vic_req = 1'b0; vic_set = '0; vic_ack = 1'b0;
    step();
    step();
    chk("rst_vld", 32'(vic_vld), 0);
    chk("rst_way", 32'(vic_way), 0);
    chk("rst_rdy", 32'(vic_rdy), 0);
    chk("rst_err", 32'(vic_err), 0);
    chk("rst_drop", 32'(hit_drop), 0);

    // Hits throughout INIT must be ignored without hit_drop.
    rst = 1'b0;
    hit_en = 1'b1; hit_set = 4'd5; hit_way = 3'd7;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("init_rdy_drop_%0d", i), 32'({vic_rdy, hit_drop}), 0);
      step();
    end
    hit_en = 1'b0;
    chk("init_done_rdy", 32'(vic_rdy), 1);
    chk_set("init_set5", 5, id);
    chk_set("init_set0", 0, id);
    chk_set("init_set15", 15, id);

    // Basic victim handshake on set 5.
    do_req(5);
    chk("s5_lookup_vld", 32'(vic_vld), 0);
    chk("s5_lookup_rdy", 32'(vic_rdy), 0);
    step();
    chk("s5_vld", 32'(vic_vld), 1);
    chk("s5_way", 32'(vic_way), 7);
    chk("s5_err", 32'(vic_err), 0);
    step();
    chk("s5_hold_vld", 32'(vic_vld), 1);
    vic_ack = 1'b1;
    step();
    vic_ack = 1'b0;
    chk("s5_ack_vld", 32'(vic_vld), 0);
    chk("s5_ack_rdy", 32'(vic_rdy), 1);
    chk_set("s5_ack_ages", 5, mk(1, 2, 3, 4, 5, 6, 7, 0));

    // Hit-update vector table.
    for (int i = 0; i < 7; i++) begin
      hit(vecs[i].set, vecs[i].way);
      chk_set($sformatf("hitvec_%0d_s%0d_w%0d", i, vecs[i].set, vecs[i].way),
              vecs[i].set, vecs[i].exp);
      chk($sformatf("hitvec_%0d_drop", i), 32'(hit_drop), 0);
    end

    // Hit during HOLD modifies ages but not the held victim.
    hit(3, 7);
    do_req(3);
    step();
    chk("s3_way", 32'(vic_way), 6);
    hit(3, 6);
    chk("s3_hold_way", 32'(vic_way), 6);
    chk("s3_hold_vld", 32'(vic_vld), 1);
    chk_set("s3_hold_ages", 3, mk(2, 3, 4, 5, 6, 7, 0, 1));
    vic_ack = 1'b1;
    step();
    vic_ack = 1'b0;
    chk_set("s3_ack_ages", 3, mk(2, 3, 4, 5, 6, 7, 0, 1));

    // Hit in LOOKUP to the latched set is seen by selection.
    do_req(6);
    hit(6, 7);
    chk("s6_bypass_way", 32'(vic_way), 6);
    vic_ack = 1'b1;
    step();
    vic_ack = 1'b0;
    chk_set("s6_ack_ages", 6, mk(2, 3, 4, 5, 6, 7, 0, 1));

    // Ack and hit to the same set: the hit is dropped.
    do_req(2);
    step();
    chk("s2_way", 32'(vic_way), 7);
    vic_ack = 1'b1;
    hit(2, 0);
    vic_ack = 1'b0;
    chk("s2_drop", 32'(hit_drop), 1);
    chk_set("s2_ages", 2, mk(1, 2, 3, 4, 5, 6, 7, 0));
    chk("s2_vld", 32'(vic_vld), 0);
    step();
    chk("s2_drop_end", 32'(hit_drop), 0);

    // Ack and hit to different sets: both apply.
    do_req(7);
    step();
    vic_ack = 1'b1;
    hit(8, 5);
    vic_ack = 1'b0;
    chk("s7s8_drop", 32'(hit_drop), 0);
    chk_set("s7_ages", 7, mk(1, 2, 3, 4, 5, 6, 7, 0));
    chk_set("s8_ages", 8, mk(1, 2, 3, 4, 5, 0, 6, 7));

    // Ack outside HOLD is ignored.
    hit(7, 0);
    chk_set("s7_hit_ages", 7, mk(0, 2, 3, 4, 5, 6, 7, 1));
    vic_ack = 1'b1;
    step();
    vic_ack = 1'b0;
    chk_set("idle_ack_ages", 7, mk(0, 2, 3, 4, 5, 6, 7, 1));
    chk("idle_ack_vld", 32'(vic_vld), 0);
    chk("idle_ack_rdy", 32'(vic_rdy), 1);

    // No way aged 7: error pulse and way 0.
    dut.age_reg[4] = 24'd0;
    do_req(4);
    step();
    chk("s4_err", 32'(vic_err), 1);
    chk("s4_way", 32'(vic_way), 0);
    chk("s4_vld", 32'(vic_vld), 1);
    step();
    chk("s4_err_end", 32'(vic_err), 0);
    vic_ack = 1'b1;
    step();
    vic_ack = 1'b0;

    // Reset during HOLD abandons the victim and re-initialises.
    do_req(5);
    step();
    chk("rh_vld_before", 32'(vic_vld), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rh_vld", 32'(vic_vld), 0);
    chk("rh_rdy", 32'(vic_rdy), 0);
    for (int i = 0; i < 16; i++)
      step();
    chk("rh_rdy_done", 32'(vic_rdy), 1);
    chk_set("rh_set4", 4, id);
    chk_set("rh_set1", 1, id);
    chk_set("rh_set5", 5, id);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lru8_victim_sel.md
LRU8_VICTIM_SEL -- requirements
Module: lru8_victim_sel

Interface
REQ-001 SHALL have parameter SETS, default 16, meaning the number of LRU sets held (SETW = log2(SETS) = 4).
REQ-002 SHALL have port clk, input, 1 bit, the single clock.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port hit_en, input, 1 bit, which requests an age update for a hit.
REQ-005 SHALL have port hit_set, input, SETW bits, which selects the set for the hit update.
REQ-006 SHALL have port hit_way, input, 3 bits, which names the way that was hit.
REQ-007 SHALL have port vic_req, input, 1 bit, which requests a victim for a fill.
REQ-008 SHALL have port vic_set, input, SETW bits, which selects the set for the victim request.
REQ-009 SHALL have port vic_rdy, output, 1 bit, which indicates the block can accept vic_req.
REQ-010 SHALL have port vic_vld, output, 1 bit, which indicates vic_way is valid.
REQ-011 SHALL have port vic_way, output, 3 bits, which carries the selected victim way (age 7).
REQ-012 SHALL have port vic_ack, input, 1 bit, by which the consumer takes the victim and commits the fill.
REQ-013 SHALL have port vic_err, output, 1 bit, which pulses when no way in the set has age 7.
REQ-014 SHALL have port hit_drop, output, 1 bit, which pulses when a hit update is discarded.

Function
REQ-015 SHALL store 8 three-bit ages per set in registers; ages within a set SHALL always form a permutation of 0..7, where 0 is the MRU way and 7 is the LRU way.
REQ-016 SHALL implement the states INIT, IDLE, LOOKUP and HOLD.
REQ-017 INIT SHALL write one set per cycle, sets 0..SETS-1 in order, giving way k age k; it SHALL go to IDLE after SETS cycles, with vic_rdy=0 and hits ignored (no hit_drop) throughout INIT.
REQ-018 A hit update SHALL take effect at the next edge: way hit_way gets age 0, every way with age < old age(hit_way) increments, and all other ways are unchanged.
REQ-019 In IDLE, vic_rdy SHALL be 1; vic_req sampled high at edge N SHALL latch vic_set and move the state to LOOKUP.
REQ-020 LOOKUP SHALL find the way with age 7 in the latched set, register it onto vic_way, set vic_vld=1 from edge N+1, and move to HOLD.
REQ-021 If no way has age 7, vic_err SHALL pulse for one cycle, vic_way SHALL be 0, and the handshake SHALL proceed normally.
REQ-022 In HOLD, vic_vld and vic_way SHALL remain stable until vic_ack is sampled high, even when hits modify the latched set.
REQ-023 When vic_ack is sampled in HOLD, vic_way SHALL be promoted to age 0 in the latched set using the REQ-018 rule applied to its current age; vic_vld SHALL drop and the state SHALL return to IDLE.
REQ-024 vic_rdy SHALL be 0 in LOOKUP and HOLD; vic_ack outside HOLD SHALL be ignored.
REQ-025 When a hit and an ack promotion target the same set in the same cycle, the ack SHALL win, the hit SHALL be discarded, and hit_drop SHALL pulse for one cycle.
REQ-026 Same-cycle hit and ack promotion to different sets SHALL both apply.
REQ-027 A hit in LOOKUP to the latched set SHALL apply before selection, so selection sees post-hit ages in the same cycle (bypass).

Reset
REQ-028 On rst sampled high, the state SHALL become INIT, vic_vld=0, vic_way=0, vic_rdy=0, vic_err=0 and hit_drop=0, and the INIT set pointer SHALL be 0.
REQ-029 rst asserted mid-INIT, LOOKUP or HOLD SHALL abandon the operation, drop any pending victim without promotion, and restart INIT from set 0.

Configuration
REQ-030 Macro LRU8_DOUBLE_HIT_EN defined SHALL add the ports hit2_en (1 bit), hit2_set (SETW bits) and hit2_way (3 bits).
REQ-031 With LRU8_DOUBLE_HIT_EN defined, two hits to the same set with different ways SHALL give hit_way age 0 and hit2_way age 1, with the other ways shifted to keep a permutation.
REQ-032 With LRU8_DOUBLE_HIT_EN defined, two hits to the same set and way SHALL behave as a single hit.
REQ-033 With LRU8_DOUBLE_HIT_EN defined, two hits to different sets SHALL both apply independently.
REQ-034 With LRU8_DOUBLE_HIT_EN defined, ack collision with either hit SHALL drop that hit and pulse hit_drop.
REQ-035 Without LRU8_DOUBLE_HIT_EN, the hit2_* ports SHALL be absent and behaviour SHALL be exactly REQ-018..027.

Verification
REQ-036 Reset, then wait: vic_rdy=0 for 16 cycles, then 1; set 5 ages = {0,1,2,3,4,5,6,7} for ways 0..7.
REQ-037 After init, vic_req set 5 -> vic_vld=1 two edges later with vic_way=7; vic_ack -> set 5 ages = {1,2,3,4,5,6,7,0}.
REQ-038 Hit set 3 way 7 then vic_req set 3 -> vic_way=6; hit set 3 way 6 during HOLD -> vic_way stays 6; ack -> way 6 age 0, way 7 age 1.
REQ-039 In HOLD on set 2, assert vic_ack together with hit set 2 way 0 -> hit_drop=1 for one cycle; ages reflect only the promotion.
REQ-040 Force set 4 ages to all 0 (backdoor), vic_req set 4 -> vic_err=1 pulse, vic_way=0.
REQ-041 Assert rst while in HOLD -> vic_vld=0 the next cycle, INIT restarts, and ages return to the initial values.
